useq_sequencer: RTL and testbench

- Microprogram sequencer, the reader side of the 23-bit-wide, 18-deep microcode control ROM (5-bit address, combinational read).
- Drives the ROM address, decodes each returned word into a next-address decision and a 15-bit control vector, and issues that vector to the multiplier datapath (Robertson's algorithm).
- Sits between the top-level start/done handshake and the datapath; samples three datapath status flags for branching.

---
 rtl/useq_pkg.sv | 38 +++
 rtl/useq_next_addr.sv | 45 ++++
 rtl/useq_sequencer.sv | 128 ++++++++++++
 tb/tb_useq_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared widths, microword field positions and enums for the microprogram sequencer.
package useq_pkg;

    localparam int ADDR_W    = 5;
    localparam int WORD_W    = 23;
    localparam int CTRL_W    = 15;
    localparam int FLAG_W    = 3;
    localparam int ROM_DEPTH = 18;

    localparam int COND_MSB  = 22;
    localparam int COND_LSB  = 20;
    localparam int TGT_MSB   = 19;
    localparam int TGT_LSB   = 15;
    localparam int CTRL_MSB  = 14;

    typedef enum logic [2:0] {
        ALWAYS   = 3'b000,
        IF_F0    = 3'b001,
        IF_F1    = 3'b010,
        IF_F2    = 3'b011,
        ALWAYS_B = 3'b100,
        IFN_F0   = 3'b101,
        IFN_F1   = 3'b110,
        IFN_F2   = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Both unconditional encodings count as a jump, and as a halt when self-targeted.
    function automatic logic isUncond(input cond_e c);
        return (c == ALWAYS) || (c == ALWAYS_B);
    endfunction

endpackage

// File: rtl/useq_next_addr.sv
// Combinational next-address logic: branch decision, halt detection and illegal-address check.
module useq_next_addr
    import useq_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int DEPTH = ROM_DEPTH
) (
    input  logic [2:0]    cond_i,
    input  logic [AW-1:0] target_i,
    input  logic [AW-1:0] upc_i,
    input  logic [2:0]    flags_i,
    output logic [AW-1:0] next_addr_o,
    output logic          halt_o,
    output logic          illegal_o
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    cond_e         condSel;
    logic          takeJump;
    logic [AW-1:0] nextAddr;

    assign condSel = cond_e'(cond_i);

    always_comb begin
        takeJump = 1'b0;
        case (condSel)
            ALWAYS, ALWAYS_B: takeJump = 1'b1;
            IF_F0:            takeJump = flags_i[0];
            IF_F1:            takeJump = flags_i[1];
            IF_F2:            takeJump = flags_i[2];
            IFN_F0:           takeJump = ~flags_i[0];
            IFN_F1:           takeJump = ~flags_i[1];
            IFN_F2:           takeJump = ~flags_i[2];
            default:          takeJump = 1'b0;
        endcase
    end

    // Sequential fall-through wraps modulo 2^AW; only the depth check can reject it.
    assign nextAddr    = takeJump ? target_i : (upc_i + AW'(1));
    assign next_addr_o = nextAddr;
    assign halt_o      = isUncond(condSel) && (target_i == upc_i);
    assign illegal_o   = ({1'b0, nextAddr} >= DEPTH_L);

endmodule

// File: rtl/useq_sequencer.sv
// Microprogram sequencer driving the control ROM and issuing datapath control words.
// Optional step watchdog enabled by defining USEQ_WATCHDOG_EN.
module useq_sequencer
    import useq_pkg::*;
#(
    parameter int AW         = ADDR_W,
    parameter int DW         = WORD_W,
    parameter int DEPTH      = ROM_DEPTH,
    parameter int START_ADDR = 0
`ifdef USEQ_WATCHDOG_EN
    ,
    parameter int MAX_STEPS  = 255
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    flags,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [14:0]   ctrl,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [AW-1:0] START_L = AW'(START_ADDR);

    state_e        state_q, state_d;
    logic [AW-1:0] upc_q, upc_d;
    logic          error_q, error_d;

    logic [AW-1:0] nextAddr;
    logic          halt;
    logic          illegal;
    logic          watchdogTrip;

    useq_next_addr #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_next_addr (
        .cond_i      (rom_data[COND_MSB:COND_LSB]),
        .target_i    (rom_data[TGT_MSB:TGT_LSB]),
        .upc_i       (upc_q),
        .flags_i     (flags),
        .next_addr_o (nextAddr),
        .halt_o      (halt),
        .illegal_o   (illegal)
    );

`ifdef USEQ_WATCHDOG_EN
    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS - 1);

    logic [7:0] steps_q, steps_d;

    // steps_q counts words already issued this run, so the limit trips on the last allowed word.
    assign watchdogTrip = (steps_q == STEP_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            steps_q <= 8'd0;
        end else begin
            steps_q <= steps_d;
        end
    end

    always_comb begin
        steps_d = steps_q;
        if (state_q == RUN) begin
            steps_d = steps_q + 8'd1;
        end else if (start) begin
            steps_d = 8'd0;
        end
    end
`else
    assign watchdogTrip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            upc_q   <= START_L;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            error_q <= error_d;
        end
    end

    // A halt takes priority over both abnormal endings; upc is frozen when leaving RUN.
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        error_d = error_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    upc_d   = START_L;
                    error_d = 1'b0;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = DONE;
                end else if (illegal || watchdogTrip) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end else begin
                    upc_d = nextAddr;
                end
            end
            default: begin
                state_d = IDLE;
                upc_d   = START_L;
                error_d = 1'b0;
            end
        endcase
    end

    assign rom_addr = upc_q;
    assign busy     = ~reset && (state_q == RUN);
    assign done     = ~reset && (state_q == DONE);
    assign error    = done && error_q;
    assign ctrl     = busy ? rom_data[CTRL_MSB:0] : 15'd0;

endmodule

// File: tb/tb_useq_sequencer.sv
// Scoreboard bench for useq_sequencer: directed runs against a hand-written Robertson ROM image.
module tb_useq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  flags;
    logic [4:0]  rom_addr;
    logic [22:0] rom_data;
    logic [14:0] ctrl;
    logic        busy;
    logic        done;
    logic        error;

    logic [22:0] rom [32];
    logic [14:0] ctrlTab [32];

    typedef struct packed {
        logic        isDone;
        logic [4:0]  addr;
        logic [14:0] ctrl;
        logic        err;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    logic doneSeen = 1'b0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

`ifdef USEQ_WATCHDOG_EN
    useq_sequencer #(.MAX_STEPS(40)) dut (
`else
    useq_sequencer dut (
`endif
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flags    (flags),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ctrl     (ctrl),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pushWord(input int a);
        expQ.push_back('{isDone: 1'b0, addr: a[4:0], ctrl: ctrlTab[a], err: 1'b0});
    endtask

    task automatic pushDone(input logic err);
        expQ.push_back('{isDone: 1'b1, addr: 5'd0, ctrl: 15'd0, err: err});
    endtask

    task automatic applyStimulus(input logic [2:0] f);
        flags = f;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitSize(input int left, input int budget, input string name);
        int n = 0;
        while (expQ.size() > left && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() > left) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=%0d pending required=%0d", name, expQ.size(), left);
            expQ.delete();
        end
    endtask

    function automatic int loopAddr(input int k);
        int idx;
        if (k < 9) return k;
        idx = (k - 9) % 8;
        case (idx)
            0: return 10;
            1: return 11;
            default: return idx + 1;
        endcase
    endfunction

    // Monitor: one scoreboard entry per issued word and one per entry into DONE.
    always @(negedge clk) begin : monitor
        expT e;
        if (busy) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word actual=addr %0d required=no word", rom_addr);
            end else begin
                e = expQ.pop_front();
                checkOutput("word_kind", 32'(done), 32'(e.isDone));
                checkOutput("word_addr", 32'(rom_addr), 32'(e.addr));
                checkOutput("word_ctrl", 32'(ctrl), 32'(e.ctrl));
            end
        end
        if (done && !doneSeen) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=done error=%0d required=no done", error);
            end else begin
                e = expQ.pop_front();
                checkOutput("done_kind", 32'(done), 32'(e.isDone));
                checkOutput("done_error", 32'(error), 32'(e.err));
            end
        end
        doneSeen = done;
    end

    initial begin
        ctrlTab = '{15'h0003, 15'h0011, 15'h0300, 15'h0040, 15'h0005, 15'h0006, 15'h0120, 15'h0A00,
                    15'h0008, 15'h4000, 15'h0081, 15'h0012, 15'h0C00, 15'h0033, 15'h1100, 15'h2001,
                    15'h0404, 15'h7000, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0,
                    15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0};
        for (int a = 0; a < 32; a++) rom[a] = {3'b010, 5'd0, ctrlTab[a]};
        rom[3]  = {3'b001, 5'd12, ctrlTab[3]};
        rom[8]  = {3'b101, 5'd10, ctrlTab[8]};
        rom[9]  = {3'b000, 5'd9,  ctrlTab[9]};
        rom[11] = {3'b000, 5'd3,  ctrlTab[11]};
        rom[17] = {3'b100, 5'd17, ctrlTab[17]};

        reset = 1'b1;
        start = 1'b0;
        flags = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_ctrl", 32'(ctrl), 32'd0);

        $display("[TB] Robertson run, flags=001");
        for (int a = 0; a < 4; a++) pushWord(a);
        for (int a = 12; a < 18; a++) pushWord(a);
        pushDone(1'b0);
        applyStimulus(3'b001);
        waitSize(0, 40, "robertson");

        $display("[TB] illegal target at addr 1");
        rom[1] = {3'b000, 5'd20, ctrlTab[1]};
        pushWord(0);
        pushWord(1);
        pushDone(1'b1);
        applyStimulus(3'b001);
        waitSize(0, 20, "illegal");
        rom[1] = {3'b010, 5'd0, ctrlTab[1]};

        $display("[TB] restart from DONE with start pulses mid-run");
        for (int a = 0; a < 4; a++) pushWord(a);
        for (int a = 12; a < 18; a++) pushWord(a);
        pushDone(1'b0);
        applyStimulus(3'b001);
        @(negedge clk);
        checkOutput("restart_error", 32'(error), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitSize(0, 40, "restart");

        $display("[TB] inverted condition at addr 4");
        rom[4] = {3'b101, 5'd9, ctrlTab[4]};
        for (int a = 0; a < 5; a++) pushWord(a);
        pushWord(9);
        pushDone(1'b0);
        applyStimulus(3'b000);
        waitSize(0, 30, "inv_f0_low");
        for (int a = 0; a < 10; a++) pushWord(a);
        pushDone(1'b0);
        applyStimulus(3'b000);
        waitSize(7, 30, "inv_reach4");
        #1 flags = 3'b001;
        waitSize(0, 30, "inv_f0_high");
        rom[4] = {3'b010, 5'd0, ctrlTab[4]};

        $display("[TB] reset mid-run at addr 5");
        for (int a = 0; a < 5; a++) pushWord(a);
        applyStimulus(3'b000);
        waitSize(0, 30, "midrun");
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_ctrl", 32'(ctrl), 32'd0);
        checkOutput("midreset_upc", 32'(rom_addr), 32'd5);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_busy", 32'(busy), 32'd0);
        checkOutput("after_reset_done", 32'(done), 32'd0);
        checkOutput("after_reset_addr", 32'(rom_addr), 32'd0);

`ifdef USEQ_WATCHDOG_EN
        $display("[TB] endless loop, watchdog at 40 words");
        for (int k = 0; k < 40; k++) pushWord(loopAddr(k));
        pushDone(1'b1);
        applyStimulus(3'b000);
        waitSize(0, 100, "watchdog");
`else
        $display("[TB] endless loop, 1000 busy cycles");
        for (int k = 0; k < 1000; k++) pushWord(loopAddr(k));
        applyStimulus(3'b000);
        waitSize(0, 1100, "loop");
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
`endif
        repeat (3) @(posedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
